// File: rtl/delay_meas_sequencer_if.sv
// Path-under-test stimulus/capture signals plus the result record valid/ready channel.
interface delay_meas_sequencer_if #(
  parameter int unsigned PATH_W = 3,
  parameter int unsigned CNT_W  = 5
);
  logic [PATH_W-1:0] path_sel;
  logic              path_input;
  logic              path_result;
  logic              res_valid;
  logic              res_ready;
  logic [PATH_W-1:0] res_path;
  logic              res_edge;
  logic [CNT_W-1:0]  res_count;

  modport master (
    output path_sel, path_input, res_valid, res_path, res_edge, res_count,
    input  path_result, res_ready
  );

  modport slave (
    input  path_sel, path_input, res_valid, res_path, res_edge, res_count,
    output path_result, res_ready
  );
endinterface

// File: rtl/delay_meas_sequencer.sv
// Sweeps every path with rise/fall launch trials and reports per-path/edge success counts.
// Optional macro DMS_ABORT_EN adds an abort input that returns a running sweep to IDLE.
module delay_meas_sequencer #(
  parameter int unsigned NUM_PATHS = 8,
  parameter int unsigned PATH_W    = 3,
  parameter int unsigned TRIALS    = 16,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned SETTLE    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
`ifdef DMS_ABORT_EN
  input  logic abort,
`endif
  delay_meas_sequencer_if.master bus,
  output logic busy,
  output logic done
);

  localparam int unsigned SET_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESET,
    S_LAUNCH,
    S_REPORT,
    S_FINISH
  } state_t;

  state_t            state;
  logic [PATH_W-1:0] path;
  logic              edge_sel;
  logic [CNT_W-1:0]  trial;
  logic [CNT_W-1:0]  succ;
  logic [SET_W-1:0]  settle;
  logic              path_input;
  logic              res_valid;
  logic [PATH_W-1:0] res_path;
  logic              res_edge;
  logic [CNT_W-1:0]  res_count;

  // Success when the captured value already shows the launch level (inverse of pre-level).
  logic             hit_c;
  logic [CNT_W-1:0] succ_next_c;
  assign hit_c       = (bus.path_result == ~edge_sel);
  assign succ_next_c = succ + CNT_W'(hit_c);

  assign bus.path_sel   = path;
  assign bus.path_input = path_input;
  assign bus.res_valid  = res_valid;
  assign bus.res_path   = res_path;
  assign bus.res_edge   = res_edge;
  assign bus.res_count  = res_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      path       <= '0;
      edge_sel   <= 1'b0;
      trial      <= '0;
      succ       <= '0;
      settle     <= '0;
      path_input <= 1'b0;
      res_valid  <= 1'b0;
      res_path   <= '0;
      res_edge   <= 1'b0;
      res_count  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end
`ifdef DMS_ABORT_EN
    else if (abort && (state != S_IDLE)) begin
      // Drop any pending record and stop driving the path.
      state      <= S_IDLE;
      trial      <= '0;
      succ       <= '0;
      settle     <= '0;
      path_input <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end
`endif
    else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          path_input <= 1'b0;
          if (start) begin
            state    <= S_PRESET;
            path     <= '0;
            edge_sel <= 1'b0;
            trial    <= '0;
            succ     <= '0;
            settle   <= '0;
            busy     <= 1'b1;
          end
        end
        S_PRESET: begin
          if (settle == SET_W'(SETTLE - 1)) begin
            state      <= S_LAUNCH;
            settle     <= '0;
            path_input <= ~edge_sel;
          end else begin
            settle <= settle + SET_W'(1);
          end
        end
        S_LAUNCH: begin
          succ       <= succ_next_c;
          trial      <= trial + CNT_W'(1);
          path_input <= edge_sel;
          if (trial == CNT_W'(TRIALS - 1)) begin
            state     <= S_REPORT;
            res_valid <= 1'b1;
            res_path  <= path;
            res_edge  <= edge_sel;
            res_count <= succ_next_c;
          end else begin
            state <= S_PRESET;
          end
        end
        S_REPORT: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            trial     <= '0;
            succ      <= '0;
            if (!edge_sel) begin
              state      <= S_PRESET;
              edge_sel   <= 1'b1;
              path_input <= 1'b1;
            end else if (path != PATH_W'(NUM_PATHS - 1)) begin
              state      <= S_PRESET;
              path       <= path + PATH_W'(1);
              edge_sel   <= 1'b0;
              path_input <= 1'b0;
            end else begin
              state      <= S_FINISH;
              path_input <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          res_valid  <= 1'b0;
          path_input <= 1'b0;
        end
      endcase
    end
  end

endmodule
